// File: rtl/proc_fetch_resp_unit_pkg.sv
// Shared types and constants for the fetch response unit; no logic, no latency.
// Count width helper sizes in-flight/occupancy counters for any FIFO depth.
package proc_fetch_resp_unit_pkg;

  localparam int P_NUM_ENTRIES_DEFAULT = 2;
  localparam logic [31:0] RESET_INST = 32'h00000000;

  typedef logic [$clog2(P_NUM_ENTRIES_DEFAULT+1)-1:0] cnt_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/proc_fetch_resp_fifo.sv
// Circular FIFO with enq/deq/flush and occupancy; head visible the cycle after enqueue.
// No internal backpressure: the producer must never enqueue into a full FIFO.
module proc_fetch_resp_fifo
  import proc_fetch_resp_unit_pkg::*;
#(
  parameter int p_num_entries = P_NUM_ENTRIES_DEFAULT,
  parameter int p_data_width  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enq,
  input  logic [p_data_width-1:0]               enq_data,
  input  logic                                  deq,
  input  logic                                  flush,
  output logic [p_data_width-1:0]               deq_data,
  output logic [cnt_width(p_num_entries)-1:0]   occ
);

  localparam int CW = cnt_width(p_num_entries);
  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [PW-1:0] LAST = PW'(p_num_entries - 1);
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [p_data_width-1:0] mem [p_num_entries];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  assign deq_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (deq) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      occ <= occ + CW'(enq) - CW'(deq);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && !flush && occ == FULL));

endmodule

// File: rtl/proc_fetch_resp_unit.sv
// Credit-based imem fetch issue, response buffering and redirect squash; inst one cycle after resp
// (same cycle with PROC_FETCH_RESP_BYPASS_EN). Fetch stalls when buffer+in-flight credits run out.
module proc_fetch_resp_unit
  import proc_fetch_resp_unit_pkg::*;
#(
  parameter int p_num_entries = P_NUM_ENTRIES_DEFAULT,
  parameter int p_data_width  = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch_val,
  output logic                                 fetch_rdy,
  output logic                                 imem_req_val,
  input  logic                                 imem_req_rdy,
  input  logic                                 imem_resp_val,
  output logic                                 imem_resp_rdy,
  input  logic [p_data_width-1:0]              imem_resp_data,
  input  logic                                 drop,
  output logic                                 inst_val,
  input  logic                                 inst_rdy,
  output logic [p_data_width-1:0]              inst_data,
  output logic [cnt_width(p_num_entries)-1:0]  num_inflight
);

  localparam int CW = cnt_width(p_num_entries);
  localparam logic [CW:0] DEPTH = (CW+1)'(p_num_entries);

  logic [CW-1:0]           inflight;
  logic [CW-1:0]           drop_cnt;
  logic [CW-1:0]           occ;
  logic [p_data_width-1:0] fifo_head;
  logic                    credit_ok;
  logic                    req_fire;
  logic                    resp_fire;
  logic                    resp_keep;
  logic                    byp;
  logic                    fifo_enq;
  logic                    fifo_deq;

  assign credit_ok     = ({1'b0, occ} + {1'b0, inflight}) < DEPTH;
  assign fetch_rdy     = ~reset & credit_ok & imem_req_rdy;
  assign imem_req_val  = ~reset & credit_ok & fetch_val;
  assign req_fire      = imem_req_val & imem_req_rdy;
  assign imem_resp_rdy = ~reset;
  assign resp_fire     = imem_resp_val & imem_resp_rdy;
  // Responses of squashed fetches are discarded while drop_cnt drains.
  assign resp_keep     = resp_fire & ~drop & (drop_cnt == '0);

`ifdef PROC_FETCH_RESP_BYPASS_EN
  assign byp = resp_keep & (occ == '0);
`else
  assign byp = 1'b0;
`endif

  assign inst_val  = ((occ != '0) & ~drop) | byp;
  assign inst_data = reset ? p_data_width'(RESET_INST) : (byp ? imem_resp_data : fifo_head);
  assign fifo_enq  = resp_keep & ~(byp & inst_rdy);
  assign fifo_deq  = (occ != '0) & ~drop & inst_rdy;

  assign num_inflight = inflight;

  proc_fetch_resp_fifo #(
    .p_num_entries (p_num_entries),
    .p_data_width  (p_data_width)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .enq      (fifo_enq),
    .enq_data (imem_resp_data),
    .deq      (fifo_deq),
    .flush    (drop),
    .deq_data (fifo_head),
    .occ      (occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(resp_fire);
      // A redirect reloads rather than accumulates; the redirect request itself is kept.
      if (drop)
        drop_cnt <= inflight - CW'(resp_fire);
      else if (resp_fire && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_proc_fetch_resp_unit.sv
// Directed bench for proc_fetch_resp_unit with a 3-deep buffer (allows a redirect fetch
// alongside two squashed ones); inputs change 1 time unit after posedge, checks 3 units after.
module tb_proc_fetch_resp_unit;

  logic        clk;
  logic        reset;
  logic        fetch_val;
  logic        fetch_rdy;
  logic        imem_req_val;
  logic        imem_req_rdy;
  logic        imem_resp_val;
  logic        imem_resp_rdy;
  logic [31:0] imem_resp_data;
  logic        drop;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst_data;
  logic [1:0]  num_inflight;

  int vectors;
  int miscompares;

  proc_fetch_resp_unit #(.p_num_entries(3), .p_data_width(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_val      (fetch_val),
    .fetch_rdy      (fetch_rdy),
    .imem_req_val   (imem_req_val),
    .imem_req_rdy   (imem_req_rdy),
    .imem_resp_val  (imem_resp_val),
    .imem_resp_rdy  (imem_resp_rdy),
    .imem_resp_data (imem_resp_data),
    .drop           (drop),
    .inst_val       (inst_val),
    .inst_rdy       (inst_rdy),
    .inst_data      (inst_data),
    .num_inflight   (num_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic rqr, input logic rsv,
                       input logic [31:0] rsd, input logic dp, input logic ir);
    fetch_val      = fv;
    imem_req_rdy   = rqr;
    imem_resp_val  = rsv;
    imem_resp_data = rsd;
    drop           = dp;
    inst_rdy       = ir;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(1, 1, 0, 32'h0, 0, 1);
    #1 reset = 1'b1;
    #2;
    check("rst_inst_val", inst_val, 0);
    check("rst_inflight", num_inflight, 0);
    check("rst_resp_rdy", imem_resp_rdy, 0);
    check("rst_fetch_rdy", fetch_rdy, 0);
    check("rst_req_val", imem_req_val, 0);
    cyc(); cyc();
    reset = 1'b0;

`ifndef PROC_FETCH_RESP_BYPASS_EN
    // Stream A, B, C with 1-cycle imem latency.
    drive(1, 1, 0, 32'h0, 0, 1); #2;
    check("s_fetch_rdy_first", fetch_rdy, 1);
    check("s_req_val_first", imem_req_val, 1);
    check("s_inst_val_c0", inst_val, 0);
    cyc();
    drive(1, 1, 1, 32'hA, 0, 1); #2;
    check("s_inst_val_c1", inst_val, 0);
    check("s_inflight_c1", num_inflight, 1);
    cyc();
    drive(1, 1, 1, 32'hB, 0, 1); #2;
    check("s_inst_val_c2", inst_val, 1);
    check("s_data_A", inst_data, 32'hA);
    cyc();
    drive(0, 1, 1, 32'hC, 0, 1); #2;
    check("s_data_B", inst_data, 32'hB);
    check("s_inflight_c3", num_inflight, 1);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("s_data_C", inst_data, 32'hC);
    check("s_inflight_c4", num_inflight, 0);
    cyc(); #2;
    check("s_empty", inst_val, 0);
    cyc();

    // Backpressure: buffer fills with inst_rdy=0.
    drive(1, 1, 0, 32'h0, 0, 0); cyc();
    drive(1, 1, 1, 32'h11, 0, 0); cyc();
    drive(1, 1, 1, 32'h22, 0, 0); cyc();
    drive(1, 1, 0, 32'h0, 0, 0); #2;
    check("bp_fetch_rdy_full", fetch_rdy, 0);
    check("bp_req_val_full", imem_req_val, 0);
    check("bp_inst_val", inst_val, 1);
    check("bp_data_11", inst_data, 32'h11);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("bp_fetch_rdy_deq_cycle", fetch_rdy, 0);
    cyc();
    drive(0, 1, 1, 32'h33, 0, 0); #2;
    check("bp_fetch_rdy_after_deq", fetch_rdy, 1);
    check("bp_data_22_hold", inst_data, 32'h22);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("bp_data_22", inst_data, 32'h22);
    cyc(); #2;
    check("bp_data_33_wrap", inst_data, 32'h33);
    cyc();

    // Redirect with two fetches in flight, target fetch issued in the drop cycle.
    drive(1, 1, 0, 32'h0, 0, 1); cyc();
    drive(1, 1, 0, 32'h0, 0, 1); #2;
    check("rd_inflight_1", num_inflight, 1);
    cyc();
    drive(1, 1, 0, 32'h0, 1, 1); #2;
    check("rd_req_val_drop", imem_req_val, 1);
    check("rd_inst_val_drop", inst_val, 0);
    cyc();
    drive(0, 1, 1, 32'hDEAD0001, 0, 1); #2;
    check("rd_inflight_3", num_inflight, 3);
    check("rd_drop_cnt_2", dut.drop_cnt, 2);
    check("rd_discard_1", inst_val, 0);
    cyc();
    drive(0, 1, 1, 32'hDEAD0002, 0, 1); #2;
    check("rd_discard_2", inst_val, 0);
    cyc();
    drive(0, 1, 1, 32'h200, 0, 1); #2;
    check("rd_drop_cnt_0", dut.drop_cnt, 0);
    check("rd_inst_val_pre", inst_val, 0);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("rd_target_val", inst_val, 1);
    check("rd_target_data", inst_data, 32'h200);
    check("rd_inflight_0", num_inflight, 0);
    cyc();

    // Drop coinciding with a response while the buffer holds one entry.
    drive(1, 1, 0, 32'h0, 0, 0); cyc();
    drive(1, 1, 1, 32'h41, 0, 0); cyc();
    drive(1, 1, 0, 32'h0, 0, 0); cyc();
    drive(0, 1, 1, 32'h42, 1, 0); #2;
    check("dr_inst_val_masked", inst_val, 0);
    cyc();
    drive(0, 1, 1, 32'h43, 0, 0); #2;
    check("dr_fifo_empty", dut.u_fifo.occ, 0);
    check("dr_inst_val", inst_val, 0);
    check("dr_drop_cnt", dut.drop_cnt, 1);
    check("dr_inflight", num_inflight, 1);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 0); #2;
    check("dr_inst_val_after", inst_val, 0);
    check("dr_drop_cnt_0", dut.drop_cnt, 0);
    check("dr_inflight_0", num_inflight, 0);
    cyc();

    // Reset asserted between edges with one buffered and one in flight.
    drive(1, 1, 0, 32'h0, 0, 0); cyc();
    drive(1, 1, 1, 32'h51, 0, 0); cyc();
    drive(1, 1, 0, 32'h0, 0, 0); #2;
    check("mr_inst_val_pre", inst_val, 1);
    check("mr_inflight_pre", num_inflight, 1);
    #1 reset = 1'b1;
    #1;
    check("mr_inst_val", inst_val, 0);
    check("mr_inflight", num_inflight, 0);
    check("mr_fetch_rdy", fetch_rdy, 0);
    check("mr_req_val", imem_req_val, 0);
    check("mr_resp_rdy", imem_resp_rdy, 0);
    drive(0, 1, 1, 32'h52, 0, 1);
    cyc();
    reset = 1'b0;
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("mr_stale_val", inst_val, 0);
    check("mr_inflight_post", num_inflight, 0);
    cyc(); #2;
    check("mr_stale_val2", inst_val, 0);
`else
    // Bypass: empty buffer, response consumed in the same cycle.
    drive(1, 1, 0, 32'h0, 0, 1); cyc();
    drive(0, 1, 1, 32'h00000013, 0, 1); #2;
    check("by_inst_val", inst_val, 1);
    check("by_inst_data", inst_data, 32'h00000013);
    cyc();
    drive(0, 1, 0, 32'h0, 0, 1); #2;
    check("by_occ", dut.u_fifo.occ, 0);
    check("by_inst_val_after", inst_val, 0);
    check("by_inflight", num_inflight, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
